core_read_arbiter: RTL and testbench
====================================

Name:
core_read_arbiter

Overview:
- Shares one AXI-lite read port (AR/R) between the core's instruction fetch master and the LSU data-read master, so both can sit behind a single memory/interconnect read path.
- Sits between the core's two read masters and the memory-side read port.
- One transaction outstanding at a time; round-robin grant on contention; address registered before it is issued downstream.

Parameters:
ADDR_WIDTH, 32, width of all ARADDR signals
DATA_WIDTH, 32, width of all RDATA signals

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr_ARADDR  in  ADDR_WIDTH  fetch read address
instr_ARVALID  in  1  fetch address valid
instr_ARREADY  out  1  fetch address accepted
instr_RDATA  out  DATA_WIDTH  fetch read data
instr_RVALID  out  1  fetch read data valid
instr_RREADY  in  1  fetch ready for data
data_ARADDR  in  ADDR_WIDTH  LSU read address
data_ARVALID  in  1  LSU address valid
data_ARREADY  out  1  LSU address accepted
data_RDATA  out  DATA_WIDTH  LSU read data
data_RVALID  out  1  LSU read data valid
data_RREADY  in  1  LSU ready for data
mem_ARADDR  out  ADDR_WIDTH  shared read address
mem_ARVALID  out  1  shared address valid
mem_ARREADY  in  1  slave accepts address
mem_RDATA  in  DATA_WIDTH  slave read data
mem_RVALID  in  1  slave data valid
mem_RREADY  out  1  ready toward slave

Behaviour:
- State machine: IDLE, ADDR, DATA.
- Registers: addr_q, grant_q (0=instr, 1=data), last_q.
- Reset: state=IDLE, addr_q=0, grant_q=0, last_q=0 (instr).
- Reset values of outputs: all VALID/READY outputs 0, mem_ARADDR=0, RDATA outputs 0.
- Reset asserted mid-transaction: aborts to IDLE immediately; the pending slave response is not tracked.
- IDLE, only one ARVALID high: that master gets ARREADY=1 in the same cycle (combinational on its ARVALID). Latch addr_q and grant_q, go to ADDR.
- IDLE, both ARVALID high: grant the master not equal to last_q. Out of reset the data master wins the first tie.
- IDLE, no ARVALID high: stay in IDLE.
- Every handshake sets last_q=grant_q.
- Outside IDLE: instr_ARREADY=0 and data_ARREADY=0. A pending request holds ARVALID and ADDR stable per AXI.
- ADDR: mem_ARVALID=1, mem_ARADDR=addr_q. Go to DATA on mem_ARREADY=1.
- mem_ARADDR equals addr_q in every state (0 after reset).
- DATA: mem_RREADY = RREADY of the granted master.
  - The granted master's RVALID = mem_RVALID; the other master's RVALID = 0.
  - Both RDATA outputs = mem_RDATA (combinational pass-through).
- DATA exit: on mem_RVALID & mem_RREADY go to IDLE. A new grant is possible the next cycle.
- Minimum latency: AR handshake at cycle 0, mem_ARVALID at cycle 1. With mem_ARREADY=1 in cycle 1 and RVALID in cycle 2, the master sees data in cycle 2 and the arbiter is back in IDLE at cycle 3.
- mem_ARVALID never drops before mem_ARREADY.
- The ungranted requester waits without limit; round-robin bounds its wait to one transaction under contention.

Test Plan:
- Reset mid-DATA (rst=1 for 1 cycle) -> next cycle state IDLE, all valids/readies 0; a fresh instr request completes normally.
- Single instr read, addr 0x10, slave ARREADY=1 immediately, RDATA=0xDEADBEEF one cycle later -> instr_ARREADY at cycle 0, mem_ARADDR=0x10 at cycle 1, instr_RVALID=1 with 0xDEADBEEF at cycle 2, data_RVALID stays 0.
- Both request at the same cycle after reset (instr 0x4, data 0x100) -> data served first (mem_ARADDR=0x100), then instr (0x4).
- Both request continuously for 4 transactions -> grant order data, instr, data, instr.
- Slave holds mem_ARREADY=0 for 3 cycles -> mem_ARVALID and mem_ARADDR stable for those 3 cycles; both upstream ARREADY stay 0.
- Granted data master holds data_RREADY=0 for 2 cycles while mem_RVALID=1 -> mem_RREADY=0 for those 2 cycles, state stays DATA; completes when RREADY=1.

Source files
------------

// File: rtl/core_read_arbiter.sv
// Two-master AXI-lite read arbiter: instruction fetch and LSU share one AR/R port.
// One transaction in flight; round-robin on contention; address registered before issue.
module core_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] instr_ARADDR,
  input  logic                  instr_ARVALID,
  output logic                  instr_ARREADY,
  output logic [DATA_WIDTH-1:0] instr_RDATA,
  output logic                  instr_RVALID,
  input  logic                  instr_RREADY,

  input  logic [ADDR_WIDTH-1:0] data_ARADDR,
  input  logic                  data_ARVALID,
  output logic                  data_ARREADY,
  output logic [DATA_WIDTH-1:0] data_RDATA,
  output logic                  data_RVALID,
  input  logic                  data_RREADY,

  output logic [ADDR_WIDTH-1:0] mem_ARADDR,
  output logic                  mem_ARVALID,
  input  logic                  mem_ARREADY,
  input  logic [DATA_WIDTH-1:0] mem_RDATA,
  input  logic                  mem_RVALID,
  output logic                  mem_RREADY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  grant_q;   // 0 = instr, 1 = data
  logic                  last_q;    // master served by the most recent grant
  logic                  arvalid_q;

  logic in_idle_c;
  logic in_data_c;
  logic pick_data_c;
  logic ar_hs_c;
  logic r_hs_c;

  assign in_idle_c = (state_q == IDLE);
  assign in_data_c = (state_q == DATA);

  // On a tie the master that was not served last wins.
  assign pick_data_c = data_ARVALID && (!instr_ARVALID || !last_q);

  assign instr_ARREADY = !rst && in_idle_c && instr_ARVALID && !pick_data_c;
  assign data_ARREADY  = !rst && in_idle_c && pick_data_c;
  assign ar_hs_c       = instr_ARREADY || data_ARREADY;

  assign mem_ARADDR  = addr_q;
  assign mem_ARVALID = arvalid_q;

  // Response path is routed to the granted master only while a read is in its data phase.
  assign mem_RREADY   = in_data_c && (grant_q ? data_RREADY : instr_RREADY);
  assign instr_RVALID = in_data_c && !grant_q && mem_RVALID;
  assign data_RVALID  = in_data_c && grant_q && mem_RVALID;
  assign instr_RDATA  = in_data_c ? mem_RDATA : '0;
  assign data_RDATA   = in_data_c ? mem_RDATA : '0;
  assign r_hs_c       = mem_RVALID && mem_RREADY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs_c) begin
            addr_q    <= pick_data_c ? data_ARADDR : instr_ARADDR;
            grant_q   <= pick_data_c;
            last_q    <= pick_data_c;
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (mem_ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (r_hs_c) begin
            state_q <= IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_read_arbiter.sv
// Bench for core_read_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_core_read_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] instr_ARADDR, data_ARADDR, mem_ARADDR;
  logic          instr_ARVALID, instr_ARREADY, instr_RVALID, instr_RREADY;
  logic          data_ARVALID, data_ARREADY, data_RVALID, data_RREADY;
  logic [DW-1:0] instr_RDATA, data_RDATA, mem_RDATA;
  logic          mem_ARVALID, mem_ARREADY, mem_RVALID, mem_RREADY;

  core_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .instr_ARADDR(instr_ARADDR), .instr_ARVALID(instr_ARVALID), .instr_ARREADY(instr_ARREADY),
    .instr_RDATA(instr_RDATA), .instr_RVALID(instr_RVALID), .instr_RREADY(instr_RREADY),
    .data_ARADDR(data_ARADDR), .data_ARVALID(data_ARVALID), .data_ARREADY(data_ARREADY),
    .data_RDATA(data_RDATA), .data_RVALID(data_RVALID), .data_RREADY(data_RREADY),
    .mem_ARADDR(mem_ARADDR), .mem_ARVALID(mem_ARVALID), .mem_ARREADY(mem_ARREADY),
    .mem_RDATA(mem_RDATA), .mem_RVALID(mem_RVALID), .mem_RREADY(mem_RREADY)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stim bits: {instr_ARVALID, data_ARVALID, mem_ARREADY, mem_RVALID, instr_RREADY, data_RREADY}
  // exp bits:  {instr_ARREADY, data_ARREADY, mem_ARVALID, mem_RREADY, instr_RVALID, data_RVALID}
  typedef struct {
    logic [5:0]  stim;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] mrd;
    logic [5:0]  exp;
    logic [31:0] maa;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [12];

  int          order[$];
  logic [31:0] aq[$];
  int          exp_ord[4];
  logic [31:0] ia_n, da_n, exp_a;

  // random-run reference model state
  logic        req[2];
  logic [31:0] raddr[2];
  logic        busy, addr_done, gm, last_m, eg, exp_iar, exp_dar, hs, mar_hs, r_hs;
  logic [31:0] gaddr, sl_addr;
  logic        sl_pend;
  int          sl_dly;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_ARADDR = '0; instr_ARVALID = 1'b0; instr_RREADY = 1'b0;
    data_ARADDR  = '0; data_ARVALID  = 1'b0; data_RREADY  = 1'b0;
    mem_ARREADY  = 1'b0; mem_RVALID = 1'b0; mem_RDATA = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] resp(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  initial begin
    tbl[0]  = '{6'b100000, 32'h10, 32'h0,   32'h0,        6'b100000, 32'h0,   32'h0};
    tbl[1]  = '{6'b001010, 32'h10, 32'h0,   32'h0,        6'b001000, 32'h10,  32'h0};
    tbl[2]  = '{6'b000110, 32'h10, 32'h0,   32'hDEADBEEF, 6'b000110, 32'h10,  32'hDEADBEEF};
    tbl[3]  = '{6'b110000, 32'h4,  32'h100, 32'h0,        6'b010000, 32'h10,  32'h0};
    tbl[4]  = '{6'b101000, 32'h4,  32'h100, 32'h0,        6'b001000, 32'h100, 32'h0};
    tbl[5]  = '{6'b100101, 32'h4,  32'h0,   32'hCAFE0001, 6'b000101, 32'h100, 32'hCAFE0001};
    tbl[6]  = '{6'b100000, 32'h4,  32'h0,   32'h0,        6'b100000, 32'h100, 32'h0};
    tbl[7]  = '{6'b000000, 32'h4,  32'h0,   32'h0,        6'b001000, 32'h4,   32'h0};
    tbl[8]  = '{6'b001000, 32'h4,  32'h0,   32'h0,        6'b001000, 32'h4,   32'h0};
    tbl[9]  = '{6'b000100, 32'h4,  32'h0,   32'h12345678, 6'b000010, 32'h4,   32'h12345678};
    tbl[10] = '{6'b000110, 32'h4,  32'h0,   32'h12345678, 6'b000110, 32'h4,   32'h12345678};
    tbl[11] = '{6'b000000, 32'h4,  32'h0,   32'h0,        6'b000000, 32'h4,   32'h0};
    exp_ord = '{1, 0, 1, 0};

    // Reset values, with every input pushing for activity.
    idle_inputs();
    rst = 1'b1;
    instr_ARVALID = 1'b1; data_ARVALID = 1'b1; mem_RVALID = 1'b1;
    instr_RREADY = 1'b1; data_RREADY = 1'b1; mem_ARREADY = 1'b1; mem_RDATA = 32'h55AA55AA;
    #2;
    chk("rst instr_ARREADY", 64'(instr_ARREADY), 64'(0));
    chk("rst data_ARREADY",  64'(data_ARREADY),  64'(0));
    chk("rst mem_ARVALID",   64'(mem_ARVALID),   64'(0));
    chk("rst mem_ARADDR",    64'(mem_ARADDR),    64'(0));
    chk("rst mem_RREADY",    64'(mem_RREADY),    64'(0));
    chk("rst instr_RVALID",  64'(instr_RVALID),  64'(0));
    chk("rst data_RVALID",   64'(data_RVALID),   64'(0));
    chk("rst instr_RDATA",   64'(instr_RDATA),   64'(0));
    chk("rst data_RDATA",    64'(data_RDATA),    64'(0));
    do_reset();

    // Vector table: single instr read, tie after instr, stalls.
    for (int i = 0; i < 12; i++) begin
      {instr_ARVALID, data_ARVALID, mem_ARREADY, mem_RVALID, instr_RREADY, data_RREADY} = tbl[i].stim;
      instr_ARADDR = tbl[i].ia;
      data_ARADDR  = tbl[i].da;
      mem_RDATA    = tbl[i].mrd;
      #2;
      chk($sformatf("v%0d instr_ARREADY", i), 64'(instr_ARREADY), 64'(tbl[i].exp[5]));
      chk($sformatf("v%0d data_ARREADY", i),  64'(data_ARREADY),  64'(tbl[i].exp[4]));
      chk($sformatf("v%0d mem_ARVALID", i),   64'(mem_ARVALID),   64'(tbl[i].exp[3]));
      chk($sformatf("v%0d mem_RREADY", i),    64'(mem_RREADY),    64'(tbl[i].exp[2]));
      chk($sformatf("v%0d instr_RVALID", i),  64'(instr_RVALID),  64'(tbl[i].exp[1]));
      chk($sformatf("v%0d data_RVALID", i),   64'(data_RVALID),   64'(tbl[i].exp[0]));
      chk($sformatf("v%0d mem_ARADDR", i),    64'(mem_ARADDR),    64'(tbl[i].maa));
      chk($sformatf("v%0d instr_RDATA", i),   64'(instr_RDATA),   64'(tbl[i].rd));
      chk($sformatf("v%0d data_RDATA", i),    64'(data_RDATA),    64'(tbl[i].rd));
      tick();
    end

    // Continuous contention from reset: data, instr, data, instr.
    do_reset();
    ia_n = 32'h4; da_n = 32'h100;
    mem_ARREADY = 1'b1; mem_RVALID = 1'b1; mem_RDATA = 32'h77;
    instr_RREADY = 1'b1; data_RREADY = 1'b1;
    for (int c = 0; c < 40 && (order.size() < 4 || aq.size() > 0); c++) begin
      instr_ARVALID = (order.size() < 4);
      data_ARVALID  = (order.size() < 4);
      instr_ARADDR  = ia_n;
      data_ARADDR   = da_n;
      #2;
      if (mem_ARVALID && mem_ARREADY) begin
        if (aq.size() > 0) begin
          exp_a = aq.pop_front();
          chk("grant mem_ARADDR", 64'(mem_ARADDR), 64'(exp_a));
        end else begin
          chk("grant unexpected mem_ARVALID", 64'(mem_ARVALID), 64'(0));
        end
      end
      if (data_ARREADY && data_ARVALID) begin
        order.push_back(1); aq.push_back(da_n); da_n = da_n + 32'h4;
      end else if (instr_ARREADY && instr_ARVALID) begin
        order.push_back(0); aq.push_back(ia_n); ia_n = ia_n + 32'h4;
      end
      tick();
    end
    chk("grant count", 64'(order.size()), 64'(4));
    for (int k = 0; k < order.size() && k < 4; k++)
      chk($sformatf("grant order %0d", k), 64'(order[k]), 64'(exp_ord[k]));
    idle_inputs();
    mem_RVALID = 1'b1; instr_RREADY = 1'b1; data_RREADY = 1'b1;
    for (int k = 0; k < 4; k++) tick();

    // Slave holds mem_ARREADY low for 3 cycles, then data master stalls RREADY.
    idle_inputs();
    data_ARVALID = 1'b1; data_ARADDR = 32'h300;
    #2;
    chk("stall data_ARREADY", 64'(data_ARREADY), 64'(1));
    tick();
    data_ARVALID = 1'b0;
    instr_ARVALID = 1'b1; instr_ARADDR = 32'h8;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("stall mem_ARVALID",   64'(mem_ARVALID),   64'(1));
      chk("stall mem_ARADDR",    64'(mem_ARADDR),    64'(32'h300));
      chk("stall instr_ARREADY", 64'(instr_ARREADY), 64'(0));
      chk("stall data_ARREADY",  64'(data_ARREADY),  64'(0));
      tick();
    end
    mem_ARREADY = 1'b1;
    #2;
    chk("stall release mem_ARVALID", 64'(mem_ARVALID), 64'(1));
    tick();
    mem_ARREADY = 1'b0;
    mem_RVALID = 1'b1; mem_RDATA = 32'hABCD; instr_RREADY = 1'b1; data_RREADY = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2;
      chk("rready mem_RREADY",   64'(mem_RREADY),   64'(0));
      chk("rready data_RVALID",  64'(data_RVALID),  64'(1));
      chk("rready instr_RVALID", 64'(instr_RVALID), 64'(0));
      chk("rready data_RDATA",   64'(data_RDATA),   64'(32'hABCD));
      tick();
    end
    data_RREADY = 1'b1;
    #2;
    chk("rready release mem_RREADY", 64'(mem_RREADY), 64'(1));
    tick();
    mem_RVALID = 1'b0;
    #2;
    chk("after data instr_ARREADY", 64'(instr_ARREADY), 64'(1));
    tick();
    instr_ARVALID = 1'b0; mem_ARREADY = 1'b1;
    #2;
    chk("pre-reset mem_ARADDR", 64'(mem_ARADDR), 64'(32'h8));
    tick();

    // Reset in the DATA phase, then a fresh instr read.
    mem_ARREADY = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_RVALID = 1'b1; mem_RDATA = 32'h1111; instr_RREADY = 1'b1;
    #2;
    chk("midrst instr_RVALID",  64'(instr_RVALID),  64'(0));
    chk("midrst mem_RREADY",    64'(mem_RREADY),    64'(0));
    chk("midrst mem_ARVALID",   64'(mem_ARVALID),   64'(0));
    chk("midrst mem_ARADDR",    64'(mem_ARADDR),    64'(0));
    chk("midrst instr_ARREADY", 64'(instr_ARREADY), 64'(0));
    chk("midrst data_ARREADY",  64'(data_ARREADY),  64'(0));
    mem_RVALID = 1'b0;
    instr_ARVALID = 1'b1; instr_ARADDR = 32'h20;
    #2;
    chk("fresh instr_ARREADY", 64'(instr_ARREADY), 64'(1));
    tick();
    instr_ARVALID = 1'b0; mem_ARREADY = 1'b1;
    #2;
    chk("fresh mem_ARVALID", 64'(mem_ARVALID), 64'(1));
    chk("fresh mem_ARADDR",  64'(mem_ARADDR),  64'(32'h20));
    tick();
    mem_ARREADY = 1'b0; mem_RVALID = 1'b1; mem_RDATA = 32'h600D;
    #2;
    chk("fresh instr_RVALID", 64'(instr_RVALID), 64'(1));
    chk("fresh instr_RDATA",  64'(instr_RDATA),  64'(32'h600D));
    tick();
    mem_RVALID = 1'b0;
    #2;
    chk("fresh done instr_RVALID", 64'(instr_RVALID), 64'(0));
    chk("fresh done mem_ARVALID",  64'(mem_ARVALID),  64'(0));

    // Randomized traffic against a transaction-level model.
    do_reset();
    req[0] = 1'b0; req[1] = 1'b0; raddr[0] = '0; raddr[1] = '0;
    busy = 1'b0; addr_done = 1'b0; gm = 1'b0; last_m = 1'b0; gaddr = '0;
    sl_pend = 1'b0; sl_addr = '0; sl_dly = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && $urandom_range(2) == 0) begin
          req[m] = 1'b1;
          raddr[m] = $urandom() & 32'hFFFF_FFFC;
        end
      end
      instr_ARVALID = req[0]; instr_ARADDR = raddr[0];
      data_ARVALID  = req[1]; data_ARADDR  = raddr[1];
      instr_RREADY = 1'($urandom_range(1));
      data_RREADY  = 1'($urandom_range(1));
      mem_ARREADY  = 1'($urandom_range(1));
      mem_RVALID   = sl_pend && (sl_dly == 0);
      mem_RDATA    = mem_RVALID ? resp(sl_addr) : $urandom();
      #2;
      exp_iar = 1'b0; exp_dar = 1'b0; eg = 1'b0;
      if (!busy && (req[0] || req[1])) begin
        eg = (req[0] && req[1]) ? !last_m : req[1];
        exp_iar = !eg;
        exp_dar = eg;
      end
      chk("rnd instr_ARREADY", 64'(instr_ARREADY), 64'(exp_iar));
      chk("rnd data_ARREADY",  64'(data_ARREADY),  64'(exp_dar));
      chk("rnd mem_ARVALID",   64'(mem_ARVALID),   64'(busy && !addr_done));
      chk("rnd mem_RREADY",    64'(mem_RREADY),
          64'(busy && addr_done && (gm ? data_RREADY : instr_RREADY)));
      chk("rnd instr_RVALID",  64'(instr_RVALID),  64'(busy && addr_done && !gm && mem_RVALID));
      chk("rnd data_RVALID",   64'(data_RVALID),   64'(busy && addr_done && gm && mem_RVALID));
      hs     = exp_iar || exp_dar;
      mar_hs = busy && !addr_done && mem_ARREADY;
      r_hs   = busy && addr_done && mem_RVALID && (gm ? data_RREADY : instr_RREADY);
      if (mar_hs) chk("rnd mem_ARADDR", 64'(mem_ARADDR), 64'(gaddr));
      if (r_hs) chk("rnd RDATA", 64'(gm ? data_RDATA : instr_RDATA), 64'(resp(gaddr)));
      tick();
      if (r_hs) begin
        busy = 1'b0; addr_done = 1'b0; sl_pend = 1'b0;
      end else if (mar_hs) begin
        addr_done = 1'b1; sl_pend = 1'b1; sl_addr = gaddr; sl_dly = int'($urandom_range(3));
      end else if (sl_pend && sl_dly > 0) begin
        sl_dly--;
      end
      if (hs) begin
        busy = 1'b1; gm = eg; last_m = eg; gaddr = raddr[eg]; req[eg] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
